sync_timing_ctrl: RTL and testbench
===================================

SYNC_TIMING_CTRL -- requirements
Module: sync_timing_ctrl

Interface
REQ-001 Parameter PEAK_WIN, default 16, number of samples searched for the correlation peak after the first threshold crossing.
REQ-002 Parameter SYM_LEN, default 80, samples per OFDM symbol (CP plus body).
REQ-003 Parameter FIRST_OFF, default 32, samples from the peak sample to the first sym_start; legal range PEAK_WIN..255.
REQ-004 Parameter SEARCH_TO, default 4095, maximum samples spent in SEARCH before timeout.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin acquisition.
REQ-008 abort  input  1  synchronous abort of any activity.
REQ-009 in_valid  input  1  sample strobe from the front end.
REQ-010 thresh  input  8  unsigned detection threshold, sampled on accepted start.
REQ-011 num_sym  input  8  symbols to time after lock, sampled on accepted start.
REQ-012 corr_re, corr_im  input  7  signed two's-complement correlator outputs, valid in the same cycle as corr_ena.
REQ-013 corr_ena  output  1  enable to the correlator shift chain.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 locked  output  1  high in LOCKED.
REQ-016 sym_start  output  1  one-cycle pulse on the first sample of each timed symbol.
REQ-017 peak_mag  output  8  magnitude of the selected peak.
REQ-018 frame_done, timeout  output  1  one-cycle completion and failure pulses.

Function
REQ-019 corr_ena SHALL equal in_valid AND (state != IDLE), combinationally; a sample is "accepted" when corr_ena=1.
REQ-020 Magnitude SHALL be |corr_re|+|corr_im| as 8-bit unsigned (range 0..128); |-64| = 64 with no saturation.
REQ-021 States: IDLE, FLUSH, SEARCH, PEAK, LOCKED; all counters advance only on accepted samples.
REQ-022 IDLE: start=1 -> FLUSH next cycle, latching thresh and num_sym (num_sym=0 latched as 1); start in any other state SHALL be ignored.
REQ-023 FLUSH: after 63 accepted samples -> SEARCH, so the 64-tap chain holds only new samples; magnitudes are ignored in FLUSH.
REQ-024 SEARCH: first accepted sample with mag >= thresh -> PEAK, with that sample as the initial peak (peak_mag, peak position 0).
REQ-025 SEARCH: SEARCH_TO accepted samples without a crossing -> IDLE with a timeout pulse in the cycle of the transition.
REQ-026 PEAK: for the next PEAK_WIN-1 accepted samples, peak_mag/position update only when mag is strictly greater; ties keep the earliest sample.
REQ-027 After PEAK_WIN accepted samples (crossing sample included) -> LOCKED; the since-peak count equals samples elapsed after the chosen peak sample.
REQ-028 LOCKED: sym_start SHALL pulse in the cycle of the accepted sample that is FIRST_OFF samples after the peak sample, then every SYM_LEN accepted samples.
REQ-029 After the num_sym-th sym_start, frame_done SHALL pulse in the cycle of the next accepted sample, with transition to IDLE.
REQ-030 sym_start, frame_done and timeout SHALL be registered, never high together, and each high for exactly one cycle.
REQ-031 abort=1 in any state -> IDLE next cycle, no frame_done or timeout pulse, peak_mag held; abort has priority over start and every transition.
REQ-032 in_valid gaps SHALL stall all counters with no state change; mag in non-accepted cycles is ignored.
REQ-033 peak_mag SHALL clear to 0 on accepted start and stay valid from LOCKED entry until the next start.

Reset
REQ-034 rst=0 at a clock edge -> IDLE; corr_ena, busy, locked, sym_start, frame_done, timeout = 0; peak_mag = 0; all counters 0.
REQ-035 Reset mid-operation SHALL behave like abort, but also clears peak_mag.

Verification
REQ-036 start, thresh=40, num_sym=2, in_valid=1 always, peak mag 60 at accepted sample 100 (SEARCH entered at sample 63) -> sym_start at samples 132 and 212, frame_done at 213, peak_mag=60.
REQ-037 Crossing mag 41 then 55 and 55 within the window -> peak_mag=55, timing taken from the first 55.
REQ-038 thresh=200 (unreachable) -> timeout pulse after 63+4095 accepted samples, busy low next cycle, no sym_start.
REQ-039 in_valid toggling 1/0 through FLUSH and LOCKED -> identical sym_start sample indices to REQ-036, at twice the cycle count.
REQ-040 abort during LOCKED, then rst=0 mid-FLUSH -> IDLE, outputs zero, no frame_done; start with num_sym=0 yields exactly one sym_start.

Source files
------------

// File: rtl/sync_timing_ctrl_if.sv
// Handshake/sample bundle between the front end and the timing controller.
interface sync_timing_ctrl_if;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [7:0] thresh;
  logic [7:0] num_sym;
  logic [6:0] corr_re;
  logic [6:0] corr_im;
  logic       corr_ena;
  logic       busy;
  logic       locked;
  logic       sym_start;
  logic [7:0] peak_mag;
  logic       frame_done;
  logic       timeout;

  modport master (
    output start, abort, in_valid, thresh, num_sym, corr_re, corr_im,
    input  corr_ena, busy, locked, sym_start, peak_mag, frame_done, timeout
  );

  modport slave (
    input  start, abort, in_valid, thresh, num_sym, corr_re, corr_im,
    output corr_ena, busy, locked, sym_start, peak_mag, frame_done, timeout
  );
endinterface

// File: rtl/sync_timing_ctrl.sv
// OFDM symbol timing acquisition: flush the correlator, search for a threshold
// crossing, pick the strongest peak in a short window, then emit symbol strobes.
module sync_timing_ctrl #(
  parameter int unsigned PEAK_WIN  = 16,
  parameter int unsigned SYM_LEN   = 80,
  parameter int unsigned FIRST_OFF = 32,
  parameter int unsigned SEARCH_TO = 4095
) (
  input logic               clk,
  input logic               rst,
  sync_timing_ctrl_if.slave bus
);

  localparam logic [15:0] FlushLen  = 16'd63;
  localparam logic [15:0] PeakWinC  = 16'(PEAK_WIN);
  localparam logic [15:0] SymLenC   = 16'(SYM_LEN);
  localparam logic [15:0] FirstOffC = 16'(FIRST_OFF);
  localparam logic [15:0] SearchToC = 16'(SEARCH_TO);

  typedef enum logic [2:0] {StIdle, StFlush, StSearch, StPeak, StLocked} state_e;

  state_e      state_q;
  logic [7:0]  thresh_q;
  logic [7:0]  num_sym_q;
  logic [7:0]  sym_cnt_q;   // sym_starts emitted so far
  logic [7:0]  peak_mag_q;
  logic [15:0] cnt_q;       // flush / search / peak-window sample count
  logic [15:0] pos_q;       // samples since peak, then since last sym_start
  logic        sym_start_q;
  logic        frame_done_q;
  logic        timeout_q;

  logic        accept;
  logic [7:0]  re_ext, im_ext, abs_re, abs_im, mag;
  logic [15:0] sym_target;

  // Sample acceptance and |re|+|im| magnitude (|-64| = 64 fits in 8 bits).
  always_comb begin
    accept     = bus.in_valid && (state_q != StIdle);
    re_ext     = {bus.corr_re[6], bus.corr_re};
    im_ext     = {bus.corr_im[6], bus.corr_im};
    abs_re     = re_ext[7] ? (~re_ext + 8'd1) : re_ext;
    abs_im     = im_ext[7] ? (~im_ext + 8'd1) : im_ext;
    mag        = abs_re + abs_im;
    sym_target = (sym_cnt_q == 8'd0) ? FirstOffC : SymLenC;
  end

  // Single FSM with registered pulse outputs; abort overrides every transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      thresh_q     <= 8'd0;
      num_sym_q    <= 8'd0;
      sym_cnt_q    <= 8'd0;
      peak_mag_q   <= 8'd0;
      cnt_q        <= 16'd0;
      pos_q        <= 16'd0;
      sym_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sym_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (bus.abort) begin
        state_q   <= StIdle;
        cnt_q     <= 16'd0;
        pos_q     <= 16'd0;
        sym_cnt_q <= 8'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q    <= StFlush;
              thresh_q   <= bus.thresh;
              num_sym_q  <= (bus.num_sym == 8'd0) ? 8'd1 : bus.num_sym;
              peak_mag_q <= 8'd0;
              cnt_q      <= 16'd0;
              pos_q      <= 16'd0;
              sym_cnt_q  <= 8'd0;
            end
          end
          StFlush: begin
            // Refill the 64-tap chain with 63 fresh samples before trusting it.
            if (accept) begin
              if (cnt_q == FlushLen - 16'd1) begin
                state_q <= StSearch;
                cnt_q   <= 16'd0;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          StSearch: begin
            if (accept) begin
              if (mag >= thresh_q) begin
                state_q    <= (PEAK_WIN <= 1) ? StLocked : StPeak;
                peak_mag_q <= mag;
                pos_q      <= 16'd0;
                cnt_q      <= 16'd1;
              end else if (cnt_q == SearchToC - 16'd1) begin
                state_q   <= StIdle;
                timeout_q <= 1'b1;
                cnt_q     <= 16'd0;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          StPeak: begin
            if (accept) begin
              // Strictly greater: ties keep the earliest sample.
              if (mag > peak_mag_q) begin
                peak_mag_q <= mag;
                pos_q      <= 16'd0;
              end else begin
                pos_q <= pos_q + 16'd1;
              end
              if (cnt_q == PeakWinC - 16'd1) begin
                state_q <= StLocked;
                cnt_q   <= 16'd0;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          StLocked: begin
            if (accept) begin
              if (sym_cnt_q == num_sym_q) begin
                state_q      <= StIdle;
                frame_done_q <= 1'b1;
                pos_q        <= 16'd0;
                sym_cnt_q    <= 8'd0;
              end else if (pos_q + 16'd1 == sym_target) begin
                sym_start_q <= 1'b1;
                pos_q       <= 16'd0;
                sym_cnt_q   <= sym_cnt_q + 8'd1;
              end else begin
                pos_q <= pos_q + 16'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Status decodes of the state register and registered pulses.
  always_comb begin
    bus.corr_ena   = accept;
    bus.busy       = (state_q != StIdle);
    bus.locked     = (state_q == StLocked);
    bus.sym_start  = sym_start_q;
    bus.frame_done = frame_done_q;
    bus.timeout    = timeout_q;
    bus.peak_mag   = peak_mag_q;
  end

endmodule

// File: tb/tb_sync_timing_ctrl.sv
// Directed table-driven bench for sync_timing_ctrl with default parameters.
module tb_sync_timing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sync_timing_ctrl_if bus ();

  sync_timing_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] thresh;
    logic [7:0] num_sym;
    bit         gap;
    int         p0, m0, p1, m1, p2, m2;
    int         nsym;
    int         sym0, sym1, sym2;
    int         fd;
    int         to;
    int         pk;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[7];

  task automatic check(input string what, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", what, got, exp);
    end
  endtask

  // Sample 5 is a large flush-time magnitude that must be ignored.
  function automatic int mag_at(input vec_t v, input int s);
    if (s == 5)    return 120;
    if (s == v.p0) return v.m0;
    if (s == v.p1) return v.m1;
    if (s == v.p2) return v.m2;
    return 10;
  endfunction

  task automatic set_mag(input int m);
    int re, im;
    if (m >= 128) begin
      re = -64;
      im = -64;
    end else begin
      re = m / 2;
      im = -(m - m / 2);
    end
    bus.corr_re = 7'(re);
    bus.corr_im = 7'(im);
  endtask

  task automatic do_start(input logic [7:0] th, input logic [7:0] ns);
    bus.start    = 1'b1;
    bus.thresh   = th;
    bus.num_sym  = ns;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic feed(input vec_t v, input int s0, input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      set_mag(mag_at(v, s0 + k));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    int s, cyc, nsym, fd, fd_cyc, to, stray, got_s, exp_s, exp_cyc;
    int syms[4];
    bit done, valid;
    string tag;
    tag = $sformatf("vec%0d", v.id);
    do_start(v.thresh, v.num_sym);
    check({tag, " busy_after_start"}, int'(bus.busy), 1);
    check({tag, " peak_cleared"}, int'(bus.peak_mag), 0);
    s = 0; cyc = 0; nsym = 0; fd = -1; fd_cyc = -1; to = -1; stray = 0; done = 1'b0;
    for (int i = 0; i < 4; i++) syms[i] = -1;
    while (!done && cyc < 10000) begin
      valid = v.gap ? (cyc % 2 == 0) : 1'b1;
      bus.in_valid = valid;
      set_mag(mag_at(v, s));
      @(posedge clk); #1;
      if (valid) begin
        if (bus.sym_start) begin
          if (nsym < 4) syms[nsym] = s;
          nsym++;
          if (!bus.locked) stray++;
        end
        if (bus.frame_done) begin
          fd = s;
          fd_cyc = cyc;
          done = 1'b1;
        end
        if (bus.timeout) begin
          to = s;
          done = 1'b1;
        end
        if (int'(bus.sym_start) + int'(bus.frame_done) + int'(bus.timeout) > 1) stray++;
        s++;
      end else if (bus.sym_start || bus.frame_done || bus.timeout) begin
        stray++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, " finished"}, int'(done), 1);
    check({tag, " sym_count"}, nsym, v.nsym);
    for (int i = 0; i < 3; i++) begin
      exp_s = (i == 0) ? v.sym0 : (i == 1) ? v.sym1 : v.sym2;
      got_s = (i < 4) ? syms[i] : -1;
      if (i < v.nsym) check($sformatf("%s sym%0d_sample", tag, i), got_s, exp_s);
    end
    check({tag, " frame_done_sample"}, fd, v.fd);
    exp_cyc = (v.fd < 0) ? -1 : (v.gap ? 2 * v.fd : v.fd);
    check({tag, " frame_done_cycle"}, fd_cyc, exp_cyc);
    check({tag, " timeout_sample"}, to, v.to);
    check({tag, " peak_mag"}, int'(bus.peak_mag), v.pk);
    check({tag, " busy_low_at_end"}, int'(bus.busy), 0);
    check({tag, " stray_pulses"}, stray, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0;
    bus.thresh = 8'd0; bus.num_sym = 8'd0; bus.corr_re = 7'd0; bus.corr_im = 7'd0;

    //           id thr  ns  gap  p0  m0   p1  m1   p2  m2  n  s0   s1   s2   fd   to    pk
    vecs[0] = '{0, 200, 1,  0,  -1, 0,   -1, 0,   -1, 0,  0, -1,  -1,  -1,  -1,  4157, 0};
    vecs[1] = '{1, 40,  2,  0,  100, 60, -1, 0,   -1, 0,  2, 132, 212, -1,  213, -1,   60};
    vecs[2] = '{2, 40,  2,  0,  100, 41, 105, 55, 110, 55, 2, 137, 217, -1, 218, -1,   55};
    vecs[3] = '{3, 40,  2,  1,  100, 60, -1, 0,   -1, 0,  2, 132, 212, -1,  213, -1,   60};
    vecs[4] = '{4, 40,  1,  0,  200, 50, 216, 90, 150, 35, 1, 232, -1, -1,  233, -1,   50};
    vecs[5] = '{5, 40,  3,  0,  300, 45, 315, 70, -1, 0,  3, 347, 427, 507, 508, -1,   70};
    vecs[6] = '{6, 60,  0,  0,  70, 60,  65, 59,  63, 128, 1, 95, -1,  -1,  96,  -1,   128};
    // vec6: the 128 (-64,-64) at sample 63 is the first SEARCH sample and wins.

    // Reset state with in_valid high.
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst corr_ena", int'(bus.corr_ena), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst locked", int'(bus.locked), 0);
    check("rst pulses", int'(bus.sym_start | bus.frame_done | bus.timeout), 0);
    check("rst peak_mag", int'(bus.peak_mag), 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // Reset while idle must clear the held peak from the last frame.
    check("pre_rst peak_held", int'(bus.peak_mag), 128);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst clears peak_mag", int'(bus.peak_mag), 0);

    // Abort during LOCKED; start while busy is ignored.
    do_start(8'd40, 8'd2);
    feed(vecs[1], 0, 120);
    check("abort pre locked", int'(bus.locked), 1);
    check("abort pre peak", int'(bus.peak_mag), 60);
    bus.start = 1'b1; bus.thresh = 8'd0; bus.in_valid = 1'b1; set_mag(10);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy start ignored locked", int'(bus.locked), 1);
    check("busy start ignored peak", int'(bus.peak_mag), 60);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort busy", int'(bus.busy), 0);
    check("abort locked", int'(bus.locked), 0);
    check("abort no frame_done", int'(bus.frame_done), 0);
    check("abort peak held", int'(bus.peak_mag), 60);
    check("idle corr_ena", int'(bus.corr_ena), 0);
    bus.in_valid = 1'b0;

    // Reset in the middle of FLUSH.
    do_start(8'd40, 8'd2);
    check("restart peak cleared", int'(bus.peak_mag), 0);
    feed(vecs[1], 0, 20);
    check("mid flush busy", int'(bus.busy), 1);
    bus.in_valid = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("flush rst busy", int'(bus.busy), 0);
    check("flush rst corr_ena", int'(bus.corr_ena), 0);
    check("flush rst pulses", int'(bus.sym_start | bus.frame_done | bus.timeout), 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // num_sym = 0 after recovery: exactly one sym_start.
    run_case(vecs[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
